// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - mode encodings and default width for the universal shift register
package shifter_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

endpackage

// File: rtl/shifter_next_mux.sv
// rtl/shifter_next_mux.sv - next-state select; UNIVERSAL_SHIFTER_ROTATE_EN turns shifts into rotates
module shifter_next_mux
   import shifter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] i_q,
   input  logic [1:0]       i_mode,
   input  logic [WIDTH-1:0] i_data_in,
   output logic [WIDTH-1:0] o_next_q
);

   logic w_fill_msb;
   logic w_fill_lsb;

`ifdef UNIVERSAL_SHIFTER_ROTATE_EN
   assign w_fill_msb = i_q[0];
   assign w_fill_lsb = i_q[WIDTH-1];
`else
   assign w_fill_msb = 1'b0;
   assign w_fill_lsb = 1'b0;
`endif

   // Unknown mode values fall through to default and hold the register.
   always_comb begin
      o_next_q = i_q;
      case (i_mode)
         MODE_SHR:  o_next_q = {w_fill_msb, i_q[WIDTH-1:1]};
         MODE_SHL:  o_next_q = {i_q[WIDTH-2:0], w_fill_lsb};
         MODE_LOAD: o_next_q = i_data_in;
         default:   o_next_q = i_q;
      endcase
   end

endmodule

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - hold/shift/load register; shifts rotate when UNIVERSAL_SHIFTER_ROTATE_EN is defined
module universal_shift_register
   import shifter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_next_q;

   shifter_next_mux #(.WIDTH(WIDTH)) u_next_mux (
      .i_q       (r_q),
      .i_mode    (mode),
      .i_data_in (data_in),
      .o_next_q  (w_next_q)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else begin
         r_q <= w_next_q;
      end
   end

   assign data_out = r_q;

`ifndef SYNTHESIS
   logic             r_was_hold;
   logic [WIDTH-1:0] r_q_before;

   // Remember whether the previous edge was a HOLD so the next edge can confirm q did not move.
   always_ff @(posedge clk) begin
      r_was_hold <= !reset && (mode == MODE_HOLD);
      r_q_before <= r_q;
      if (!reset) begin
         assert (!$isunknown(mode)) else $error("mode is X/Z");
      end
      if (r_was_hold === 1'b1) begin
         assert (r_q == r_q_before) else $error("data_out changed during HOLD");
      end
   end
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - directed checks of the universal shift register at WIDTH=4
module tb_universal_shift_register;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] data_in = 4'b0000;
   logic [1:0] mode = 2'b00;
   logic [3:0] data_out;

   int n_vec = 0;
   int n_err = 0;

   universal_shift_register #(.WIDTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .mode     (mode),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic [1:0] m,
                       input logic [3:0] d, input logic [3:0] exp);
      reset   = rst;
      mode    = m;
      data_in = d;
      @(posedge clk);
      #1;
      check(tag, data_out, exp);
   endtask

   initial begin
      #1;
      step("reset",      1'b1, 2'b00, 4'b1100, 4'b0000);
      step("hold0_a",    1'b0, 2'b00, 4'b1100, 4'b0000);
      step("hold0_b",    1'b0, 2'b00, 4'b1100, 4'b0000);
      step("hold0_c",    1'b0, 2'b00, 4'b1100, 4'b0000);

      step("load_1100",  1'b0, 2'b11, 4'b1100, 4'b1100);
      step("load_1010",  1'b0, 2'b11, 4'b1010, 4'b1010);
      step("hold_a",     1'b0, 2'b00, 4'b0101, 4'b1010);
      step("hold_b",     1'b0, 2'b00, 4'b1111, 4'b1010);

      step("ld_shr",     1'b0, 2'b11, 4'b1100, 4'b1100);
      step("shr_1",      1'b0, 2'b01, 4'b1111, 4'b0110);
      step("shr_2",      1'b0, 2'b01, 4'b1111, 4'b0011);
`ifdef UNIVERSAL_SHIFTER_ROTATE_EN
      step("shr_3",      1'b0, 2'b01, 4'b0000, 4'b1001);
      step("shr_4",      1'b0, 2'b01, 4'b0000, 4'b1100);
`else
      step("shr_3",      1'b0, 2'b01, 4'b0000, 4'b0001);
      step("shr_4",      1'b0, 2'b01, 4'b0000, 4'b0000);
`endif

      step("ld_shl",     1'b0, 2'b11, 4'b0011, 4'b0011);
      step("shl_1",      1'b0, 2'b10, 4'b1111, 4'b0110);
      step("shl_2",      1'b0, 2'b10, 4'b1111, 4'b1100);
`ifdef UNIVERSAL_SHIFTER_ROTATE_EN
      step("shl_3",      1'b0, 2'b10, 4'b0000, 4'b1001);
`else
      step("shl_3",      1'b0, 2'b10, 4'b0000, 4'b1000);
`endif

      step("ld_0011",    1'b0, 2'b11, 4'b0011, 4'b0011);
`ifdef UNIVERSAL_SHIFTER_ROTATE_EN
      step("shr_fill",   1'b0, 2'b01, 4'b0000, 4'b1001);
`else
      step("shr_fill",   1'b0, 2'b01, 4'b0000, 4'b0001);
`endif
      step("ld_1001",    1'b0, 2'b11, 4'b1001, 4'b1001);
`ifdef UNIVERSAL_SHIFTER_ROTATE_EN
      step("shl_fill",   1'b0, 2'b10, 4'b0000, 4'b0011);
`else
      step("shl_fill",   1'b0, 2'b10, 4'b0000, 4'b0010);
`endif

      step("ld_1111",    1'b0, 2'b11, 4'b1111, 4'b1111);
`ifdef UNIVERSAL_SHIFTER_ROTATE_EN
      step("shr_1111",   1'b0, 2'b01, 4'b0000, 4'b1111);
`else
      step("shr_1111",   1'b0, 2'b01, 4'b0000, 4'b0111);
`endif
      step("mid_reset",  1'b1, 2'b11, 4'b1010, 4'b0000);
      step("post_reset", 1'b0, 2'b11, 4'b1010, 4'b1010);

      step("reset_shl",  1'b1, 2'b10, 4'b1111, 4'b0000);
      step("shl_zero",   1'b0, 2'b10, 4'b1111, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
